mem_access_initiator: RTL and testbench

MEM-stage initiator for the data memory's valid/status handshake. Accepts one load/store at a time from the pipeline, stalls the pipeline while the request is outstanding, issues word-aligned accesses, and sign- or zero-extends loaded bytes and halfwords. Sub-word stores are performed as read-modify-write (optional). Sits between the EX/MEM pipeline register and the data memory model.

---
 rtl/mem_access_pkg.sv | 35 +++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_access_initiator.sv | 152 +++++++++++++++
 tb/tb_mem_access_initiator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types, memory status codes and fault rule for mem_access_initiator
// SUBWORD_RMW_EN selects whether sub-word stores count as legal accesses.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  localparam logic [1:0] MST_READY = 2'b00;
  localparam logic [1:0] MST_BUSY  = 2'b01;
  localparam logic [1:0] MST_DONE  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    WR_WAIT,
    DONE
  } state_e;

  // Without read-modify-write only full-word stores can reach memory.
  function automatic logic access_fault(logic [1:0] size, logic [1:0] addr_lo,
                                        logic write, logic rmw_en);
    logic f;
    f = (size == 2'b11) ||
        (size == SZ_HALF && addr_lo[0]) ||
        (size == SZ_WORD && addr_lo != 2'b00);
    if (!rmw_en && write && size != SZ_WORD) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane select/extend for loads and lane merge for stores
// Merge logic exists only when SUBWORD_RMW_EN is defined.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];

    load_value = word;
    if (size == SZ_BYTE)
      load_value = {{24{~is_unsigned & lane_b[7]}}, lane_b};
    else if (size == SZ_HALF)
      load_value = {{16{~is_unsigned & lane_h[15]}}, lane_h};
  end

`ifdef SUBWORD_RMW_EN
  always_comb begin
    merged_word = word;
    if (size == SZ_BYTE) begin
      case (addr_lo)
        2'd0:    merged_word[7:0]   = store_data[7:0];
        2'd1:    merged_word[15:8]  = store_data[7:0];
        2'd2:    merged_word[23:16] = store_data[7:0];
        default: merged_word[31:24] = store_data[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (addr_lo[1]) merged_word[31:16] = store_data[15:0];
      else            merged_word[15:0]  = store_data[15:0];
    end else begin
      merged_word = store_data;
    end
  end
`else
  // Only full-word stores exist in this build, so the store word is the data itself.
  assign merged_word = store_data;
`endif

endmodule

// File: rtl/mem_access_initiator.sv
// rtl/mem_access_initiator.sv - MEM-stage load/store initiator for the valid/status data memory
// Define SUBWORD_RMW_EN to perform byte/half stores as read-modify-write; otherwise they fault.
module mem_access_initiator
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_status
);

`ifdef SUBWORD_RMW_EN
  localparam logic RMW_EN = 1'b1;
`else
  localparam logic RMW_EN = 1'b0;
`endif

  state_e      state, state_n;
  logic [31:0] mem_addr_n, mem_wdata_n, resp_rdata_n;
  logic        mem_we_n, fault_n;
  logic [31:0] align_word, load_value, merged_word;

`ifdef SUBWORD_RMW_EN
  // The read word is parked for one cycle so the merge does not sit behind mem_rdata.
  logic        merge_pend, merge_pend_n;
  logic [31:0] word_q, word_q_n;
  assign align_word = merge_pend ? word_q : mem_rdata;
`else
  assign align_word = mem_rdata;
`endif

  // req_* is held stable by the pipeline while stall=1, so it is used directly.
  mem_lane_align u_align (
    .size        (req_size),
    .addr_lo     (req_addr[1:0]),
    .is_unsigned (req_unsigned),
    .word        (align_word),
    .store_data  (req_wdata),
    .load_value  (load_value),
    .merged_word (merged_word)
  );

  assign stall      = (state == IDLE) ? req_valid : (state != DONE);
  assign resp_valid = (state == DONE);
  assign mem_valid  = ((state == RD_ISSUE) || (state == WR_ISSUE)) && (mem_status != MST_DONE);

  always_comb begin
    state_n      = state;
    mem_addr_n   = mem_addr;
    mem_we_n     = mem_we;
    mem_wdata_n  = mem_wdata;
    resp_rdata_n = '0;
    fault_n      = 1'b0;
`ifdef SUBWORD_RMW_EN
    merge_pend_n = merge_pend;
    word_q_n     = word_q;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (access_fault(req_size, req_addr[1:0], req_write, RMW_EN)) begin
            state_n = DONE;
            fault_n = 1'b1;
          end else begin
            mem_addr_n = {req_addr[31:2], 2'b00};
            if (req_write && req_size == SZ_WORD) begin
              state_n     = WR_ISSUE;
              mem_we_n    = 1'b1;
              mem_wdata_n = merged_word;
            end else begin
              state_n  = RD_ISSUE;
              mem_we_n = 1'b0;
            end
          end
        end
      end
      RD_ISSUE: if (mem_status == MST_BUSY) state_n = RD_WAIT;
      RD_WAIT: begin
`ifdef SUBWORD_RMW_EN
        if (merge_pend) begin
          merge_pend_n = 1'b0;
          mem_we_n     = 1'b1;
          mem_wdata_n  = merged_word;
          state_n      = WR_ISSUE;
        end else if (mem_status == MST_DONE) begin
          if (req_write) begin
            word_q_n     = mem_rdata;
            merge_pend_n = 1'b1;
          end else begin
            resp_rdata_n = load_value;
            state_n      = DONE;
          end
        end
`else
        if (mem_status == MST_DONE) begin
          resp_rdata_n = load_value;
          state_n      = DONE;
        end
`endif
      end
      WR_ISSUE: if (mem_status == MST_BUSY) state_n = WR_WAIT;
      WR_WAIT:  if (mem_status == MST_DONE) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      mem_addr   <= mem_addr_n;
      mem_we     <= mem_we_n;
      mem_wdata  <= mem_wdata_n;
      resp_rdata <= resp_rdata_n;
      fault      <= fault_n;
    end
  end

`ifdef SUBWORD_RMW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      merge_pend <= 1'b0;
      word_q     <= '0;
    end else begin
      merge_pend <= merge_pend_n;
      word_q     <= word_q_n;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_initiator.sv
// tb/tb_mem_access_initiator.sv - randomized self-checking bench for mem_access_initiator
// Honours SUBWORD_RMW_EN the same way as the design.
module tb_mem_access_initiator;

  localparam int LAT = 10;
`ifdef SUBWORD_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, fault, mem_valid, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_initiator dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .fault        (fault),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_status   (mem_status)
  );

  // Data memory: done arrives LAT cycles after a request is accepted in ready.
  logic [31:0] mem [0:1023];
  logic [1:0]  m_st;
  int          m_cnt;
  logic [31:0] m_addr, m_wdata;
  logic        m_we;
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx;
  logic [31:0] bd_data;

  assign mem_status = (m_st == 2'd1) ? 2'b01 : (m_st == 2'd2) ? 2'b10 : 2'b00;
  assign mem_rdata  = (m_st == 2'd2) ? mem[m_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    if (reset) begin
      m_st <= 2'd0;
    end else begin
      case (m_st)
        2'd0: if (mem_valid) begin
          m_addr <= mem_addr; m_we <= mem_we; m_wdata <= mem_wdata;
          m_cnt <= LAT - 1; m_st <= 2'd1;
        end
        2'd1: if (m_cnt <= 1) m_st <= 2'd2; else m_cnt <= m_cnt - 1;
        default: begin
          if (m_we) mem[m_addr[11:2]] <= m_wdata;
          m_st <= 2'd0;
        end
      endcase
    end
  end

  logic [31:0] ref_mem [0:1023];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lane_bits(logic [1:0] sz);
    return (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [31:0] a, logic [1:0] sz, logic uns);
    int nb;
    logic [31:0] v, m;
    nb = lane_bits(sz);
    if (nb == 32) return w;
    m = (32'h1 << nb) - 1;
    v = (w >> (8 * a[1:0])) & m;
    if (!uns && v[nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] old, logic [31:0] a, logic [1:0] sz, logic [31:0] d);
    int nb, sh;
    logic [31:0] m;
    nb = lane_bits(sz);
    if (nb == 32) return d;
    sh = 8 * a[1:0];
    m = ((32'h1 << nb) - 1) << sh;
    return (old & ~m) | ((d << sh) & m);
  endfunction

  function automatic bit ref_fault(logic wr, logic [1:0] sz, logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0) ||
           (!RMW && wr && sz != 2'd2);
  endfunction

  task automatic poke(input logic [9:0] idx, input logic [31:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    ref_mem[idx] = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] got_rd, output int got_cyc);
    int cyc, accepts, stall_bad, dup, exp_cyc, exp_acc;
    bit seen, exp_fault, sub;
    logic [31:0] exp_rd, old;
    old       = ref_mem[addr[11:2]];
    exp_fault = ref_fault(wr, sz, addr);
    sub       = wr && sz != 2'd2;
    exp_cyc   = exp_fault ? 1 : (sub ? 2 * LAT + 4 : LAT + 2);
    exp_acc   = exp_fault ? 0 : (sub ? 2 : 1);
    exp_rd    = (exp_fault || wr) ? 32'h0 : ref_load(old, addr, sz, uns);
    if (wr && !exp_fault) ref_mem[addr[11:2]] = ref_store(old, addr, sz, wd);

    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    cyc = 0; accepts = 0; stall_bad = 0; dup = 0; seen = 0; got_rd = 'x;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      if (mem_valid && m_st == 2'd0) accepts++;
      if (mem_valid && mem_status == 2'b10) dup++;
      if (resp_valid) begin
        seen = 1;
        got_rd = resp_rdata;
        check({tag, " fault"}, fault, exp_fault);
        check({tag, " rdata"}, resp_rdata, exp_rd);
        check({tag, " stall_in_resp"}, stall, 0);
      end else begin
        if (!stall) stall_bad++;
        cyc++;
      end
    end
    req_valid = 1'b0;
    got_cyc = cyc;
    check({tag, " completed"}, seen, 1);
    check({tag, " resp_cycle"}, cyc, exp_cyc);
    check({tag, " accepts"}, accepts, exp_acc);
    check({tag, " stall_low_early"}, stall_bad, 0);
    check({tag, " valid_during_done"}, dup, 0);
    check({tag, " mem_word"}, mem[addr[11:2]], ref_mem[addr[11:2]]);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " stall"}, stall, 0);
    check({tag, " resp_valid"}, resp_valid, 0);
    check({tag, " resp_rdata"}, resp_rdata, 0);
    check({tag, " fault"}, fault, 0);
    check({tag, " mem_valid"}, mem_valid, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " mem_we"}, mem_we, 0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, d;
    int cy;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 64; i++) poke(10'(i), $urandom);
    poke(10'h40, 32'hDEADBEEF);
    poke(10'h80, 32'h11223344);
    poke(10'hC0, 32'h0);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    do_op("lw", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, cy);
    check("lw value", rd, 32'hDEADBEEF);
    check("lw cycle", cy, 12);

    poke(10'h40, 32'h80FF0000);
    do_op("lb", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, rd, cy);
    check("lb value", rd, 32'hFFFFFF80);
    do_op("lbu", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, rd, cy);
    check("lbu value", rd, 32'h00000080);
    do_op("lh", 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, rd, cy);
    check("lh value", rd, 32'hFFFF80FF);

    do_op("sb", 1'b1, 2'd0, 1'b0, 32'h201, 32'h000000AA, rd, cy);
    check("sb mem", mem[10'h80], RMW ? 32'h1122AA44 : 32'h11223344);
    check("sb cycle", cy, RMW ? 24 : 1);

    do_op("lw_mis", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, rd, cy);
    do_op("size11", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, rd, cy);

    // Reset in cycle 5 of an outstanding load.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h100;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_quiet("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    do_op("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, cy);
    check("lw_after_rst value", rd, 32'h80FF0000);

    d = $urandom;
    do_op("sw_b2b", 1'b1, 2'd2, 1'b0, 32'h300, d, rd, cy);
    do_op("lw_b2b", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, rd, cy);
    check("b2b value", rd, d);

    for (int i = 0; i < 40; i++) begin
      do_op("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom, rd, cy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
